// File: rtl/cnn_layer_accel_sysmem_rd_arb.sv
//------------------------------------------------------------------------------
// Module   : cnn_layer_accel_sysmem_rd_arb
// Brief    : Round-robin arbiter that shares the single system-memory read
//            port among the FAS buffer loader channels and steers the
//            returned beats to the granted channel's write port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cnn_layer_accel_sysmem_rd_arb #(
    parameter int C_NUM_CH     = 6,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_LEN_WIDTH  = 16,
    parameter int C_DATA_WIDTH = 128
) (
    input  logic                              clk_core,
    input  logic                              rst,
    input  logic [C_NUM_CH-1:0]               ch_req,
    input  logic [C_NUM_CH*C_ADDR_WIDTH-1:0]  ch_addr,
    input  logic [C_NUM_CH*C_LEN_WIDTH-1:0]   ch_len,
    output logic [C_NUM_CH-1:0]               ch_ack,
    output logic [C_NUM_CH-1:0]               ch_cmpl,
    output logic [C_NUM_CH-1:0]               ch_wren,
    output logic [C_DATA_WIDTH-1:0]           ch_datain,
    output logic                              sys_mem_read_req,
    input  logic                              sys_mem_read_req_ack,
    output logic [C_ADDR_WIDTH-1:0]           sys_mem_read_addr,
    output logic [C_LEN_WIDTH-1:0]            sys_mem_read_len,
    input  logic                              sys_mem_read_in_prog,
    input  logic                              sys_mem_rd_valid,
    input  logic [C_DATA_WIDTH-1:0]           sys_mem_rd_data,
    input  logic                              sys_mem_read_cmpl,
    output logic                              busy,
    output logic                              err_short,
    output logic                              err_overrun
);

    localparam int C_IDX_W = (C_NUM_CH > 1) ? $clog2(C_NUM_CH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GRANT = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_XFER  = 3'd3;
    localparam logic [2:0] S_CMPL  = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [C_IDX_W-1:0]      rr_ptr_q;
    logic [C_IDX_W-1:0]      grant_q;
    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_LEN_WIDTH-1:0]  len_q;
    logic [C_LEN_WIDTH-1:0]  beat_cnt_q;
    logic                    req_q;
    logic [C_NUM_CH-1:0]     ch_ack_q, ch_cmpl_q, ch_wren_q;
    logic [C_DATA_WIDTH-1:0] ch_datain_q;
    logic                    err_short_q, err_overrun_q;

    logic [C_ADDR_WIDTH-1:0] w_addr_arr [C_NUM_CH];
    logic [C_LEN_WIDTH-1:0]  w_len_arr  [C_NUM_CH];
    logic [C_IDX_W-1:0]      w_sel_idx, w_sel_hi, w_sel_lo;
    logic                    w_hi_found;
    logic                    w_in_xfer;
    logic                    w_beat_ok;
    logic                    w_beat_over;
    logic [C_LEN_WIDTH-1:0]  w_cnt_after;
    logic                    unused_in_prog;

    // Memory transfer status is informational only; the handshake drives control.
    assign unused_in_prog = sys_mem_read_in_prog;

    // Unpack the flat per-channel address/length buses into indexable arrays.
    for (genvar gi = 0; gi < C_NUM_CH; gi++) begin : g_unpack
        assign w_addr_arr[gi] = ch_addr[gi*C_ADDR_WIDTH +: C_ADDR_WIDTH];
        assign w_len_arr[gi]  = ch_len[gi*C_LEN_WIDTH +: C_LEN_WIDTH];
    end

    function automatic logic [C_NUM_CH-1:0] f_onehot(input logic [C_IDX_W-1:0] idx);
        f_onehot      = '0;
        f_onehot[idx] = 1'b1;
    endfunction

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall (wrap).
    always_comb begin
        w_sel_hi   = '0;
        w_sel_lo   = '0;
        w_hi_found = 1'b0;
        for (int i = C_NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                w_sel_lo = C_IDX_W'(i);
                if (C_IDX_W'(i) >= rr_ptr_q) begin
                    w_sel_hi   = C_IDX_W'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_sel_idx = w_hi_found ? w_sel_hi : w_sel_lo;
    end

    // Beat qualification; a beat arriving with the cmpl pulse counts before the short check.
    assign w_in_xfer   = (state_q == S_XFER);
    assign w_beat_ok   = w_in_xfer && sys_mem_rd_valid && (beat_cnt_q < len_q);
    assign w_beat_over = w_in_xfer && sys_mem_rd_valid && (beat_cnt_q >= len_q);
    assign w_cnt_after = beat_cnt_q + C_LEN_WIDTH'(w_beat_ok);

    // Next-state logic; zero-length grants skip the memory request entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|ch_req) state_d = S_GRANT;
            S_GRANT: state_d = (len_q == '0) ? S_CMPL : S_REQ;
            S_REQ:   if (sys_mem_read_req_ack) state_d = S_XFER;
            S_XFER:  if (sys_mem_read_cmpl) state_d = S_CMPL;
            S_CMPL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant latch, ack pulse, memory request level and round-robin pointer.
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            grant_q   <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            ch_ack_q  <= '0;
            ch_cmpl_q <= '0;
            req_q     <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            ch_ack_q  <= '0;
            ch_cmpl_q <= '0;
            if ((state_q == S_IDLE) && (|ch_req)) begin
                grant_q  <= w_sel_idx;
                addr_q   <= w_addr_arr[w_sel_idx];
                len_q    <= w_len_arr[w_sel_idx];
                ch_ack_q <= f_onehot(w_sel_idx);
            end
            if ((state_q == S_GRANT) && (len_q != '0)) begin
                req_q <= 1'b1;
            end
            if ((state_q == S_REQ) && sys_mem_read_req_ack) begin
                req_q <= 1'b0;
            end
            if (state_q == S_CMPL) begin
                ch_cmpl_q <= f_onehot(grant_q);
                rr_ptr_q  <= (grant_q == C_IDX_W'(C_NUM_CH - 1)) ? '0
                                                                 : grant_q + C_IDX_W'(1);
            end
        end
    end

    // Data steering: register each accepted beat and pulse the granted write enable.
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            beat_cnt_q  <= '0;
            ch_wren_q   <= '0;
            ch_datain_q <= '0;
        end else begin
            ch_wren_q <= '0;
            if (state_q == S_GRANT) begin
                beat_cnt_q <= '0;
            end
            if (w_beat_ok) begin
                ch_datain_q <= sys_mem_rd_data;
                ch_wren_q   <= f_onehot(grant_q);
                beat_cnt_q  <= w_cnt_after;
            end
        end
    end

    // Sticky protocol error flags, cleared only by reset.
    always_ff @(posedge clk_core or negedge rst) begin
        if (!rst) begin
            err_short_q   <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            if (w_beat_over) begin
                err_overrun_q <= 1'b1;
            end
            if (w_in_xfer && sys_mem_read_cmpl && (w_cnt_after < len_q)) begin
                err_short_q <= 1'b1;
            end
        end
    end

    assign ch_ack            = ch_ack_q;
    assign ch_cmpl           = ch_cmpl_q;
    assign ch_wren           = ch_wren_q;
    assign ch_datain         = ch_datain_q;
    assign sys_mem_read_req  = req_q;
    assign sys_mem_read_addr = addr_q;
    assign sys_mem_read_len  = len_q;
    assign busy              = (state_q != S_IDLE);
    assign err_short         = err_short_q;
    assign err_overrun       = err_overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_cnn_layer_accel_sysmem_rd_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_cnn_layer_accel_sysmem_rd_arb
// Brief    : Self-checking bench for the system-memory read arbiter using a
//            scoreboard of expected acks, write beats and completions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cnn_layer_accel_sysmem_rd_arb;

    localparam int NCH = 6;

    typedef struct {
        int           ch;
        logic [127:0] data;
    } exp_wr_t;

    logic               clk_core;
    logic               rst;
    logic [NCH-1:0]     ch_req;
    logic [NCH*32-1:0]  ch_addr;
    logic [NCH*16-1:0]  ch_len;
    logic [NCH-1:0]     ch_ack, ch_cmpl, ch_wren;
    logic [127:0]       ch_datain;
    logic               sys_mem_read_req;
    logic               sys_mem_read_req_ack;
    logic [31:0]        sys_mem_read_addr;
    logic [15:0]        sys_mem_read_len;
    logic               sys_mem_read_in_prog;
    logic               sys_mem_rd_valid;
    logic [127:0]       sys_mem_rd_data;
    logic               sys_mem_read_cmpl;
    logic               busy, err_short, err_overrun;

    int n_assert = 0;
    int n_fail   = 0;

    int      exp_ack[$];
    int      exp_cmpl[$];
    exp_wr_t exp_wr[$];

    logic [31:0] m_addr [NCH];
    logic [15:0] m_len  [NCH];

    cnn_layer_accel_sysmem_rd_arb u_dut (
        .clk_core             (clk_core),
        .rst                  (rst),
        .ch_req               (ch_req),
        .ch_addr              (ch_addr),
        .ch_len               (ch_len),
        .ch_ack               (ch_ack),
        .ch_cmpl              (ch_cmpl),
        .ch_wren              (ch_wren),
        .ch_datain            (ch_datain),
        .sys_mem_read_req     (sys_mem_read_req),
        .sys_mem_read_req_ack (sys_mem_read_req_ack),
        .sys_mem_read_addr    (sys_mem_read_addr),
        .sys_mem_read_len     (sys_mem_read_len),
        .sys_mem_read_in_prog (sys_mem_read_in_prog),
        .sys_mem_rd_valid     (sys_mem_rd_valid),
        .sys_mem_rd_data      (sys_mem_rd_data),
        .sys_mem_read_cmpl    (sys_mem_read_cmpl),
        .busy                 (busy),
        .err_short            (err_short),
        .err_overrun          (err_overrun)
    );

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH-1:0] oh(input int c);
        logic [NCH-1:0] one;
        one = 1;
        oh  = one << c;
    endfunction

    // Advance one cycle; requesters drop their level once acknowledged.
    task automatic tick();
        @(posedge clk_core);
        #1;
        ch_req = ch_req & ~ch_ack;
    endtask

    task automatic set_ch(input int ch, input logic [31:0] addr, input logic [15:0] len);
        m_addr[ch]           = addr;
        m_len[ch]            = len;
        ch_addr[ch*32 +: 32] = addr;
        ch_len[ch*16 +: 16]  = len;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ack"},    128'(ch_ack),            128'(0));
        check({tag, "_cmpl"},   128'(ch_cmpl),           128'(0));
        check({tag, "_wren"},   128'(ch_wren),           128'(0));
        check({tag, "_data"},   ch_datain,               128'(0));
        check({tag, "_req"},    128'(sys_mem_read_req),  128'(0));
        check({tag, "_addr"},   128'(sys_mem_read_addr), 128'(0));
        check({tag, "_len"},    128'(sys_mem_read_len),  128'(0));
        check({tag, "_busy"},   128'(busy),              128'(0));
        check({tag, "_eshort"}, 128'(err_short),         128'(0));
        check({tag, "_eover"},  128'(err_overrun),       128'(0));
    endtask

    // Memory-side responder for one granted transfer of channel ch.
    task automatic serve(input int ch, input int ack_dly, input int nbeats, input bit cmpl_last,
                         input int abort_after, input logic [127:0] base);
        int           n;
        int           len;
        logic [NCH-1:0] last_ack;
        exp_wr_t      e;
        len      = int'(m_len[ch]);
        n        = 0;
        last_ack = ch_ack;
        while (sys_mem_read_req !== 1'b1 && n < 100) begin
            last_ack = ch_ack;
            tick();
            n++;
        end
        check("req_seen", 128'(sys_mem_read_req), 128'(1));
        if (sys_mem_read_req !== 1'b1) return;
        check("ack_to_req", 128'(last_ack), 128'(oh(ch)));
        check("rd_addr", 128'(sys_mem_read_addr), 128'(m_addr[ch]));
        check("rd_len", 128'(sys_mem_read_len), 128'(m_len[ch]));
        check("busy_xfer", 128'(busy), 128'(1));
        for (int i = 1; i < ack_dly; i++) tick();
        check("req_hold", 128'(sys_mem_read_req), 128'(1));
        sys_mem_read_req_ack = 1'b1;
        tick();
        sys_mem_read_req_ack = 1'b0;
        sys_mem_read_in_prog = 1'b1;
        check("req_drop", 128'(sys_mem_read_req), 128'(0));
        for (int k = 0; k < nbeats; k++) begin
            sys_mem_rd_valid  = 1'b1;
            sys_mem_rd_data   = base + 128'(k);
            sys_mem_read_cmpl = cmpl_last && (k == nbeats - 1);
            if (k < len) begin
                e.ch   = ch;
                e.data = base + 128'(k);
                exp_wr.push_back(e);
            end
            if (sys_mem_read_cmpl) exp_cmpl.push_back(ch);
            tick();
            sys_mem_rd_valid  = 1'b0;
            sys_mem_read_cmpl = 1'b0;
            check("wren_lat", 128'(ch_wren), (k < len) ? 128'(oh(ch)) : 128'(0));
            if (abort_after == k + 1) begin
                sys_mem_read_in_prog = 1'b0;
                return;
            end
        end
        if (!cmpl_last) begin
            sys_mem_read_cmpl = 1'b1;
            exp_cmpl.push_back(ch);
            tick();
            sys_mem_read_cmpl = 1'b0;
        end
        sys_mem_read_in_prog = 1'b0;
        check("cmpl_wait", 128'(ch_cmpl), 128'(0));
        tick();
        check("cmpl_pulse", 128'(ch_cmpl), 128'(oh(ch)));
    endtask

    // Scoreboard monitor: every ack, write beat and completion must be expected and in order.
    always @(negedge clk_core) begin : p_mon
        int      c;
        exp_wr_t e;
        if (rst === 1'b1) begin
            if (ch_ack != '0) begin
                if (exp_ack.size() == 0) check("sb_ack_unexp", 128'(ch_ack), 128'(0));
                else begin
                    c = exp_ack.pop_front();
                    check("sb_ack", 128'(ch_ack), 128'(oh(c)));
                end
            end
            if (ch_cmpl != '0) begin
                if (exp_cmpl.size() == 0) check("sb_cmpl_unexp", 128'(ch_cmpl), 128'(0));
                else begin
                    c = exp_cmpl.pop_front();
                    check("sb_cmpl", 128'(ch_cmpl), 128'(oh(c)));
                end
            end
            if (ch_wren != '0) begin
                if (exp_wr.size() == 0) check("sb_wren_unexp", 128'(ch_wren), 128'(0));
                else begin
                    e = exp_wr.pop_front();
                    check("sb_wren", 128'(ch_wren), 128'(oh(e.ch)));
                    check("sb_data", ch_datain, e.data);
                end
            end
        end
    end

    initial begin : p_main
        int  n;
        bit  saw_req;
        rst                  = 1'b0;
        ch_req               = '0;
        ch_addr              = '0;
        ch_len               = '0;
        sys_mem_read_req_ack = 1'b0;
        sys_mem_read_in_prog = 1'b0;
        sys_mem_rd_valid     = 1'b0;
        sys_mem_rd_data      = '0;
        sys_mem_read_cmpl    = 1'b0;
        for (int i = 0; i < NCH; i++) set_ch(i, 32'h0, 16'h0);
        repeat (3) tick();
        check_idle("rst");
        rst = 1'b1;
        tick();

        // All channels pending from rr_ptr 0: grant order 0..5.
        for (int i = 0; i < NCH; i++) set_ch(i, 32'h2000 + 32'(i) * 32'h40, 16'd1);
        for (int i = 0; i < NCH; i++) exp_ack.push_back(i);
        ch_req = 6'b111111;
        for (int i = 0; i < NCH; i++) serve(i, 1, 1, 1'b1, 0, 128'hB0 + 128'(i * 16));

        // Single channel 2: addr 0x1000, len 4, ack after 3 cycles, beats A0..A3.
        set_ch(2, 32'h1000, 16'd4);
        exp_ack.push_back(2);
        ch_req[2] = 1'b1;
        serve(2, 3, 4, 1'b0, 0, 128'hA0);
        check("single_eshort", 128'(err_short), 128'(0));
        check("single_eover", 128'(err_overrun), 128'(0));
        check("single_idle", 128'(busy), 128'(0));

        // rr_ptr now 3; requests 0 and 3 give order 3 then 0.
        set_ch(0, 32'h2400, 16'd1);
        set_ch(3, 32'h2800, 16'd2);
        exp_ack.push_back(3);
        exp_ack.push_back(0);
        ch_req = 6'b001001;
        serve(3, 2, 2, 1'b0, 0, 128'h30);
        serve(0, 1, 1, 1'b0, 0, 128'h40);

        // Zero length on channel 1: ack, cmpl two cycles later, no memory request.
        set_ch(1, 32'h3000, 16'd0);
        exp_ack.push_back(1);
        exp_cmpl.push_back(1);
        ch_req[1] = 1'b1;
        saw_req   = 1'b0;
        n = 0;
        while (ch_ack == '0 && n < 20) begin
            saw_req |= sys_mem_read_req;
            tick();
            n++;
        end
        check("zl_ack", 128'(ch_ack), 128'(oh(1)));
        tick();
        saw_req |= sys_mem_read_req;
        check("zl_cmpl_early", 128'(ch_cmpl), 128'(0));
        tick();
        saw_req |= sys_mem_read_req;
        check("zl_cmpl", 128'(ch_cmpl), 128'(oh(1)));
        repeat (3) begin
            tick();
            saw_req |= sys_mem_read_req;
        end
        check("zl_noreq", 128'(saw_req), 128'(0));

        // Last beat together with cmpl, len 3: written, no short error.
        set_ch(3, 32'h4000, 16'd3);
        exp_ack.push_back(3);
        ch_req[3] = 1'b1;
        serve(3, 2, 3, 1'b1, 0, 128'hC0);
        check("sim_eshort", 128'(err_short), 128'(0));

        // Short transfer: len 4, cmpl after 2 beats.
        set_ch(4, 32'h5000, 16'd4);
        exp_ack.push_back(4);
        ch_req[4] = 1'b1;
        serve(4, 1, 2, 1'b0, 0, 128'hD0);
        check("short_eshort", 128'(err_short), 128'(1));
        check("short_eover", 128'(err_overrun), 128'(0));

        // Overrun: len 2 with 3 beats, third dropped.
        set_ch(0, 32'h6000, 16'd2);
        exp_ack.push_back(0);
        ch_req[0] = 1'b1;
        serve(0, 1, 3, 1'b0, 0, 128'hE0);
        check("over_eover", 128'(err_overrun), 128'(1));
        check("over_eshort", 128'(err_short), 128'(1));

        // Reset after 2 of 8 beats: everything clears, no completion.
        set_ch(2, 32'h7000, 16'd8);
        exp_ack.push_back(2);
        ch_req[2] = 1'b1;
        serve(2, 1, 8, 1'b0, 2, 128'hF0);
        @(negedge clk_core);
        #1;
        rst = 1'b0;
        tick();
        check_idle("midrst");
        tick();
        rst = 1'b1;
        repeat (4) tick();

        // After reset rr_ptr is 0: channels 0 and 5 complete in order 0, 5.
        set_ch(5, 32'h8000, 16'd2);
        set_ch(0, 32'h8800, 16'd1);
        exp_ack.push_back(0);
        exp_ack.push_back(5);
        ch_req = 6'b100001;
        serve(0, 1, 1, 1'b0, 0, 128'h50);
        serve(5, 2, 2, 1'b1, 0, 128'h60);
        check("post_eshort", 128'(err_short), 128'(0));
        check("post_eover", 128'(err_overrun), 128'(0));
        repeat (3) tick();

        check("sb_ack_left", 128'(exp_ack.size()), 128'(0));
        check("sb_cmpl_left", 128'(exp_cmpl.size()), 128'(0));
        check("sb_wr_left", 128'(exp_wr.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
